// File: rtl/vga_pkg.sv
// Shared types, default 640x480@60 timing and small helpers for the VGA timing generator.
// Contents: region_e (per-axis region enum), DEF_* timing constants, total/width helpers,
// and region-length / region-sequencing helpers used by the axis timers.
package vga_pkg;

  typedef enum logic [1:0] {
    REG_ACTIVE = 2'd0,
    REG_FRONT  = 2'd1,
    REG_SYNC   = 2'd2,
    REG_BACK   = 2'd3
  } region_e;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Positions per axis.
  function automatic int unsigned total_of(input int unsigned a, input int unsigned f,
                                           input int unsigned s, input int unsigned b);
    return a + f + s + b;
  endfunction

  // Bits needed to hold 0..n-1 (never below one bit).
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned region_len(input region_e r, input int unsigned a,
                                             input int unsigned f, input int unsigned s,
                                             input int unsigned b);
    case (r)
      REG_ACTIVE: return a;
      REG_FRONT:  return f;
      REG_SYNC:   return s;
      default:    return b;
    endcase
  endfunction

  function automatic region_e region_after(input region_e r);
    case (r)
      REG_ACTIVE: return REG_FRONT;
      REG_FRONT:  return REG_SYNC;
      REG_SYNC:   return REG_BACK;
      default:    return REG_ACTIVE;
    endcase
  endfunction

  // Next non-empty region; ACTIVE is never empty so the walk always terminates.
  function automatic region_e next_region(input region_e r, input int unsigned f,
                                          input int unsigned s, input int unsigned b);
    region_e c;
    c = region_after(r);
    for (int i = 0; i < 3; i++) begin
      if (region_len(c, 1, f, s, b) == 0) c = region_after(c);
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster-timing bus between the timing generator and the pixel pipeline.
// pix_en flows into the generator; sync/blank/position/pulse flags flow out.
//   master: generator side (consumes pix_en, drives timing)
//   slave : pipeline side (drives pix_en, consumes timing)
interface vga_timing_gen_if #(
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 10
);
  logic          pix_en;
  logic          hsync;
  logic          vsync;
  logic          active;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          line_start;
  logic          frame_start;

  modport master (
    input  pix_en,
    output hsync, vsync, active, x, y, line_start, frame_start
  );

  modport slave (
    output pix_en,
    input  hsync, vsync, active, x, y, line_start, frame_start
  );
endinterface

// File: rtl/vga_axis_timer.sv
// One raster axis: region FSM with a region-local down counter, a position up counter,
// a registered sync level and a registered "on last position" flag.
// Ports: clk, rst (sync, active-high), adv (advance one position),
//        region (current region), pos (0..TOTAL-1), sync (POL while in SYNC),
//        wrap (high while pos is TOTAL-1, i.e. the next advance wraps).
module vga_axis_timer
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE = 8,
  parameter int unsigned FP     = 2,
  parameter int unsigned SYNC   = 3,
  parameter int unsigned BP     = 1,
  parameter bit          POL    = 1'b0,
  localparam int unsigned TOTAL = total_of(ACTIVE, FP, SYNC, BP),
  localparam int unsigned PW    = width_of(TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  output region_e       region,
  output logic [PW-1:0] pos,
  output logic          sync,
  output logic          wrap
);

  region_e       region_q, region_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pos_q, pos_d;
  logic          sync_q, sync_d;
  logic          last_q, last_d;

  // Counter load value for a region: remaining positions after the first one.
  function automatic logic [PW-1:0] load_for(input region_e r);
    int unsigned len;
    len = region_len(r, ACTIVE, FP, SYNC, BP);
    return (len == 0) ? '0 : PW'(len - 1);
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      region_q <= REG_ACTIVE;
      cnt_q    <= PW'(ACTIVE - 1);
      pos_q    <= '0;
      sync_q   <= ~POL;
      last_q   <= (TOTAL == 1);
    end else begin
      region_q <= region_d;
      cnt_q    <= cnt_d;
      pos_q    <= pos_d;
      sync_q   <= sync_d;
      last_q   <= last_d;
    end
  end

  // Next state: region change when the down counter expires, empty regions skipped.
  always_comb begin
    region_d = region_q;
    cnt_d    = cnt_q;
    pos_d    = pos_q;
    sync_d   = sync_q;
    last_d   = last_q;
    if (adv) begin
      pos_d = last_q ? '0 : pos_q + PW'(1);
      if (cnt_q == '0) begin
        region_d = next_region(region_q, FP, SYNC, BP);
        cnt_d    = load_for(region_d);
      end else begin
        cnt_d = cnt_q - PW'(1);
      end
      // Sync level follows the region being entered so it lines up with pos.
      sync_d = (region_d == REG_SYNC) ? POL : ~POL;
      last_d = (pos_d == PW'(TOTAL - 1));
    end
  end

  assign region = region_q;
  assign pos    = pos_q;
  assign sync   = sync_q;
  assign wrap   = last_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: H and V axis timers plus registered line/frame start pulses.
// Ports: clk, rst (sync, active-high), vga (master modport: pix_en in; hsync, vsync,
//        active, x, y, line_start, frame_start out).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL = total_of(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = total_of(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned XW      = width_of(H_TOTAL);
  localparam int unsigned YW      = width_of(V_TOTAL);

  region_e       h_region, v_region;
  logic [XW-1:0] h_pos;
  logic [YW-1:0] v_pos;
  logic          h_sync, v_sync;
  logic          h_wrap, v_wrap;
  logic          v_adv;
  logic          line_start_q, frame_start_q;

  // Lines advance only on the pixel that wraps the horizontal axis.
  assign v_adv = vga.pix_en & h_wrap;

  vga_axis_timer #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HSYNC_POL)
  ) u_h_timer (
    .clk    (clk),
    .rst    (rst),
    .adv    (vga.pix_en),
    .region (h_region),
    .pos    (h_pos),
    .sync   (h_sync),
    .wrap   (h_wrap)
  );

  vga_axis_timer #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VSYNC_POL)
  ) u_v_timer (
    .clk    (clk),
    .rst    (rst),
    .adv    (v_adv),
    .region (v_region),
    .pos    (v_pos),
    .sync   (v_sync),
    .wrap   (v_wrap)
  );

  // Start pulses: set on the edge that wraps to x=0 (and y=0), cleared otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= vga.pix_en & h_wrap;
      frame_start_q <= vga.pix_en & h_wrap & v_wrap;
    end
  end

  assign vga.hsync       = h_sync;
  assign vga.vsync       = v_sync;
  assign vga.active      = (h_region == REG_ACTIVE) && (v_region == REG_ACTIVE);
  assign vga.x           = h_pos;
  assign vga.y           = v_pos;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

endmodule
